// File: rtl/cdtimer_sched_pkg.sv
// Shared types and helpers for the delta-scheduled timeout multiplexer.
package cdtimer_sched_pkg;

    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        REBASE = 2'd2
    } state_e;

    function automatic logic [CNT_W-1:0] sat_sub16(input logic [CNT_W-1:0] a,
                                                   input logic [CNT_W-1:0] b);
        return (a > b) ? CNT_W'(a - b) : '0;
    endfunction

endpackage

// File: rtl/cdtimer16.sv
// 16-bit countdown timer: decrements on each rising edge of counter_event,
// load has priority, expired is high while the count is zero.
module cdtimer16
    import cdtimer_sched_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             counter_event,
    input  logic             load,
    input  logic [CNT_W-1:0] data_in,
    output logic [CNT_W-1:0] data_out,
    output logic             expired
);

    logic             ev_q;
    logic             ev_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             expired_q;
    logic             expired_d;
    logic             ev_edge;

    assign ev_edge = counter_event & ~ev_q;

    always_comb begin
        ev_d      = counter_event;
        count_d   = count_q;
        if (load) begin
            count_d = data_in;
        end else if (ev_edge && (count_q != '0)) begin
            count_d = CNT_W'(count_q - CNT_W'(1));
        end
        expired_d = (count_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ev_q      <= 1'b0;
            count_q   <= '0;
            expired_q <= 1'b1;
        end else begin
            ev_q      <= ev_d;
            count_q   <= count_d;
            expired_q <= expired_d;
        end
    end

    assign data_out = count_q;
    assign expired  = expired_q;

endmodule

// File: rtl/cdtimer_sched.sv
// Multiplexes NCH one-shot timeouts onto one cdtimer16; the timer always
// holds the smallest remaining count and every event rebases all channels.
module cdtimer_sched
    import cdtimer_sched_pkg::*;
#(
    parameter  int unsigned NCH = 4,
    localparam int unsigned CHW = $clog2(NCH)
) (
    input  logic             sysclk,
    input  logic             sysreset_n,
    input  logic             tick,
    input  logic             req_valid,
    input  logic             req_cancel,
    input  logic [CHW-1:0]   req_ch,
    input  logic [CNT_W-1:0] req_count,
    output logic             req_ready,
    input  logic [NCH-1:0]   ack,
    output logic [NCH-1:0]   fired,
    output logic [NCH-1:0]   armed,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [NCH-1:0]   fired_q, fired_d;
    logic [NCH-1:0]   armed_q, armed_d;
    logic [CNT_W-1:0] rem_q [NCH];
    logic [CNT_W-1:0] rem_d [NCH];
    logic [CNT_W-1:0] loaded_q, loaded_d;
    logic             busy_q, busy_d;
    logic             req_ready_q, req_ready_d;
    logic             tick_q, tick_d;
    logic             pend_q, pend_d;
    logic             pcancel_q, pcancel_d;
    logic [CHW-1:0]   pch_q, pch_d;
    logic [CNT_W-1:0] pcount_q, pcount_d;

    logic             tick_edge;
    logic             req_fire;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_data;
    logic [CNT_W-1:0] tmr_data_out;
    logic             tmr_expired;
    logic [CNT_W:0]   elapsed_w;
    logic [CNT_W-1:0] elapsed;
    logic [NCH-1:0]   set_v;
    logic [CNT_W-1:0] min_v;
    logic             any_armed;

    cdtimer16 u_timer (
        .clk           (sysclk),
        .rst_n         (sysreset_n),
        .counter_event (tick),
        .load          (tmr_load),
        .data_in       (tmr_data),
        .data_out      (tmr_data_out),
        .expired       (tmr_expired)
    );

    assign tick_edge = tick & ~tick_q;
    assign req_fire  = req_valid & req_ready_q;

    // A tick during REBASE is swallowed by the timer's load, so count it here.
    assign elapsed_w = {1'b0, loaded_q} - {1'b0, tmr_data_out} + (CNT_W+1)'(tick_edge);
    assign elapsed   = (elapsed_w > {1'b0, loaded_q}) ? loaded_q : elapsed_w[CNT_W-1:0];

    always_comb begin
        state_d   = state_q;
        armed_d   = armed_q;
        rem_d     = rem_q;
        loaded_d  = loaded_q;
        tick_d    = tick;
        pend_d    = pend_q;
        pcancel_d = pcancel_q;
        pch_d     = pch_q;
        pcount_d  = pcount_q;
        set_v     = '0;
        tmr_load  = 1'b0;
        tmr_data  = '0;
        min_v     = '1;
        any_armed = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_fire && !req_cancel) begin
                    if (req_count == '0) begin
                        for (int unsigned i = 0; i < NCH; i++) begin
                            if (CHW'(i) == req_ch) set_v[i] = 1'b1;
                        end
                    end else begin
                        pend_d    = 1'b1;
                        pcancel_d = 1'b0;
                        pch_d     = req_ch;
                        pcount_d  = req_count;
                        state_d   = REBASE;
                    end
                end
            end
            RUN: begin
                if (req_fire) begin
                    pend_d    = 1'b1;
                    pcancel_d = req_cancel;
                    pch_d     = req_ch;
                    pcount_d  = req_count;
                    state_d   = REBASE;
                end else if (tmr_expired) begin
                    pend_d  = 1'b0;
                    state_d = REBASE;
                end
            end
            REBASE: begin
                for (int unsigned i = 0; i < NCH; i++) begin
                    if (armed_q[i]) begin
                        rem_d[i] = sat_sub16(rem_q[i], elapsed);
                        if (rem_d[i] == '0) begin
                            armed_d[i] = 1'b0;
                            set_v[i]   = 1'b1;
                        end
                    end
                end
                // Pending request lands on top of the rebased counts.
                if (pend_q) begin
                    for (int unsigned i = 0; i < NCH; i++) begin
                        if (CHW'(i) == pch_q) begin
                            if (pcancel_q) begin
                                armed_d[i] = 1'b0;
                            end else if (pcount_q == '0) begin
                                rem_d[i]   = '0;
                                armed_d[i] = 1'b0;
                                set_v[i]   = 1'b1;
                            end else begin
                                rem_d[i]   = pcount_q;
                                armed_d[i] = 1'b1;
                            end
                        end
                    end
                end
                for (int unsigned i = 0; i < NCH; i++) begin
                    if (armed_d[i]) begin
                        any_armed = 1'b1;
                        if (rem_d[i] < min_v) min_v = rem_d[i];
                    end
                end
                pend_d = 1'b0;
                if (any_armed) begin
                    tmr_load = 1'b1;
                    tmr_data = min_v;
                    loaded_d = min_v;
                    state_d  = RUN;
                end else begin
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        fired_d     = (fired_q & ~ack) | set_v;
        req_ready_d = (state_d != REBASE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge sysclk or negedge sysreset_n) begin
        if (!sysreset_n) begin
            state_q     <= IDLE;
            fired_q     <= '0;
            armed_q     <= '0;
            for (int unsigned i = 0; i < NCH; i++) rem_q[i] <= '0;
            loaded_q    <= '0;
            busy_q      <= 1'b0;
            req_ready_q <= 1'b1;
            tick_q      <= 1'b0;
            pend_q      <= 1'b0;
            pcancel_q   <= 1'b0;
            pch_q       <= '0;
            pcount_q    <= '0;
        end else begin
            state_q     <= state_d;
            fired_q     <= fired_d;
            armed_q     <= armed_d;
            for (int unsigned i = 0; i < NCH; i++) rem_q[i] <= rem_d[i];
            loaded_q    <= loaded_d;
            busy_q      <= busy_d;
            req_ready_q <= req_ready_d;
            tick_q      <= tick_d;
            pend_q      <= pend_d;
            pcancel_q   <= pcancel_d;
            pch_q       <= pch_d;
            pcount_q    <= pcount_d;
        end
    end

    assign fired     = fired_q;
    assign armed     = armed_q;
    assign busy      = busy_q;
    assign req_ready = req_ready_q;

endmodule

// File: tb/tb_cdtimer_sched.sv
// Directed bench for cdtimer_sched: hand-computed fire timing, cancel,
// coincident tick/rebase, reset and ack/set collision.
module tb_cdtimer_sched;

    logic        sysclk     = 1'b0;
    logic        sysreset_n = 1'b0;
    logic        tick       = 1'b0;
    logic        req_valid  = 1'b0;
    logic        req_cancel = 1'b0;
    logic [1:0]  req_ch     = '0;
    logic [15:0] req_count  = '0;
    logic [3:0]  ack        = '0;
    logic        req_ready;
    logic [3:0]  fired;
    logic [3:0]  armed;
    logic        busy;

    int vectors     = 0;
    int miscompares = 0;

    cdtimer_sched #(.NCH(4)) dut (
        .sysclk     (sysclk),
        .sysreset_n (sysreset_n),
        .tick       (tick),
        .req_valid  (req_valid),
        .req_cancel (req_cancel),
        .req_ch     (req_ch),
        .req_count  (req_count),
        .req_ready  (req_ready),
        .ack        (ack),
        .fired      (fired),
        .armed      (armed),
        .busy       (busy)
    );

    always #5 sysclk = ~sysclk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one request for a cycle, then one more cycle so REBASE completes.
    task automatic send_req(input logic cancel, input logic [1:0] ch, input logic [15:0] cnt);
        req_valid  = 1'b1;
        req_cancel = cancel;
        req_ch     = ch;
        req_count  = cnt;
        @(negedge sysclk);
        req_valid  = 1'b0;
        @(negedge sysclk);
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            @(negedge sysclk);
            tick = 1'b0;
            @(negedge sysclk);
        end
    endtask

    task automatic clear_fired();
        ack = 4'hF;
        @(negedge sysclk);
        ack = 4'h0;
    endtask

    initial begin
        repeat (3) @(negedge sysclk);
        check_eq("rst_fired", 32'(fired), 32'h0);
        check_eq("rst_armed", 32'(armed), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        check_eq("rst_ready", 32'(req_ready), 32'h1);
        sysreset_n = 1'b1;
        @(negedge sysclk);

        // Arm with zero count from IDLE fires at once, stays idle
        send_req(1'b0, 2'd2, 16'd0);
        check_eq("zero_fired", 32'(fired), 32'h4);
        check_eq("zero_armed", 32'(armed), 32'h0);
        check_eq("zero_busy", 32'(busy), 32'h0);
        send_req(1'b1, 2'd0, 16'd0);
        check_eq("idle_cancel_busy", 32'(busy), 32'h0);
        clear_fired();
        check_eq("ack_clear", 32'(fired), 32'h0);

        // Single channel, exact fire latency
        send_req(1'b0, 2'd0, 16'd5);
        check_eq("t1_armed", 32'(armed), 32'h1);
        check_eq("t1_busy", 32'(busy), 32'h1);
        check_eq("t1_ready", 32'(req_ready), 32'h1);
        tick_n(4);
        check_eq("t1_pre_fired", 32'(fired), 32'h0);
        check_eq("t1_pre_armed", 32'(armed), 32'h1);
        tick_n(1);
        check_eq("t1_t1_fired", 32'(fired), 32'h0);
        check_eq("t1_rebase_ready", 32'(req_ready), 32'h0);
        @(negedge sysclk);
        check_eq("t1_fired", 32'(fired), 32'h1);
        check_eq("t1_done_armed", 32'(armed), 32'h0);
        check_eq("t1_done_busy", 32'(busy), 32'h0);
        clear_fired();

        // Shorter timeout armed on top of a running one
        send_req(1'b0, 2'd1, 16'd10);
        tick_n(4);
        send_req(1'b0, 2'd2, 16'd3);
        check_eq("t2_armed", 32'(armed), 32'h6);
        tick_n(3);
        @(negedge sysclk);
        check_eq("t2_ch2_fired", 32'(fired), 32'h4);
        check_eq("t2_ch2_armed", 32'(armed), 32'h2);
        tick_n(2);
        check_eq("t2_ch1_early", 32'(fired), 32'h4);
        tick_n(1);
        @(negedge sysclk);
        check_eq("t2_ch1_fired", 32'(fired), 32'h6);
        check_eq("t2_done_busy", 32'(busy), 32'h0);
        clear_fired();

        // Equal counts fire together
        send_req(1'b0, 2'd0, 16'd8);
        send_req(1'b0, 2'd3, 16'd8);
        tick_n(7);
        check_eq("t3_pre_fired", 32'(fired), 32'h0);
        check_eq("t3_pre_armed", 32'(armed), 32'h9);
        tick_n(1);
        @(negedge sysclk);
        check_eq("t3_fired", 32'(fired), 32'h9);
        check_eq("t3_armed", 32'(armed), 32'h0);
        clear_fired();

        // Cancel a running channel
        send_req(1'b0, 2'd1, 16'd6);
        tick_n(2);
        send_req(1'b1, 2'd1, 16'd0);
        check_eq("t4_armed", 32'(armed), 32'h0);
        check_eq("t4_busy", 32'(busy), 32'h0);
        tick_n(20);
        check_eq("t4_fired", 32'(fired), 32'h0);

        // Tick edge lands in the REBASE cycle of an arm
        send_req(1'b0, 2'd0, 16'd4);
        req_valid  = 1'b1;
        req_cancel = 1'b0;
        req_ch     = 2'd1;
        req_count  = 16'd9;
        @(negedge sysclk);
        req_valid  = 1'b0;
        tick       = 1'b1;
        @(negedge sysclk);
        tick       = 1'b0;
        @(negedge sysclk);
        check_eq("t5_armed", 32'(armed), 32'h3);
        tick_n(3);
        check_eq("t5_ch0_early", 32'(fired), 32'h0);
        @(negedge sysclk);
        check_eq("t5_ch0_fired", 32'(fired), 32'h1);
        check_eq("t5_ch0_armed", 32'(armed), 32'h2);
        tick_n(5);
        check_eq("t5_ch1_early", 32'(fired), 32'h1);
        tick_n(1);
        @(negedge sysclk);
        check_eq("t5_ch1_fired", 32'(fired), 32'h3);
        check_eq("t5_done_busy", 32'(busy), 32'h0);

        // Async reset while running clears everything immediately
        send_req(1'b0, 2'd0, 16'd5);
        tick_n(2);
        sysreset_n = 1'b0;
        #1;
        check_eq("t6_rst_fired", 32'(fired), 32'h0);
        check_eq("t6_rst_armed", 32'(armed), 32'h0);
        check_eq("t6_rst_busy", 32'(busy), 32'h0);
        check_eq("t6_rst_ready", 32'(req_ready), 32'h1);
        @(negedge sysclk);
        sysreset_n = 1'b1;
        @(negedge sysclk);

        // Set and ack of the same bit in one cycle: set wins
        req_valid  = 1'b1;
        req_cancel = 1'b0;
        req_ch     = 2'd0;
        req_count  = 16'd0;
        ack        = 4'h1;
        @(negedge sysclk);
        req_valid  = 1'b0;
        ack        = 4'h0;
        check_eq("t6_set_wins", 32'(fired), 32'h1);
        ack = 4'h1;
        @(negedge sysclk);
        ack = 4'h0;
        check_eq("t6_ack_clear", 32'(fired), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cdtimer_sched.md
Name: cdtimer_sched

Overview:
- Multiplexes NCH independent one-shot software timeouts onto a single cdtimer16 countdown timer using delta scheduling.
- The shared timer is always loaded with the smallest remaining count among armed channels.
- On expiry or on any arm/cancel request, the block rebases every channel by the elapsed ticks, raises sticky fired flags for channels that reached zero, then reloads the timer.
- Sits between the CPU peripheral register file and the timer; the tick source is the same event strobe used by standalone timers.

Parameters:
- NCH, 4, number of timeout channels (2..8).
- CHW, $clog2(NCH), channel index width (derived, not overridden).

Ports:
- sysclk  in  1  system clock.
- sysreset_n  in  1  reset, asynchronous, active-low.
- tick  in  1  timebase event; each rising edge is one tick.
- req_valid  in  1  request strobe; accepted when req_valid && req_ready.
- req_cancel  in  1  0 = arm, 1 = cancel.
- req_ch  in  CHW  target channel.
- req_count  in  16  tick count for an arm request.
- req_ready  out  1  high in IDLE and RUN.
- ack  in  NCH  per-channel write-1-to-clear for fired.
- fired  out  NCH  sticky expiry flags.
- armed  out  NCH  channel pending.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, sysreset_n low): state = IDLE; fired = 0; armed = 0; remaining[] = 0; loaded = 0; busy = 0; req_ready = 1. The internal timer is held in reset.
- The internal cdtimer16 instance is driven as follows:
  - counter_event = tick.
  - load and data_in are driven only in the REBASE cycle.
  - Its data_out and expired are read back by this block.
- The block keeps its own tick rising-edge detector, tick_edge, in parallel with the timer's.
- State IDLE:
  - Accepted arm with req_count = 0: set fired[req_ch] on the next edge; armed is unchanged; stay in IDLE.
  - Accepted arm with req_count > 0: latch the request and go to REBASE.
  - Accepted cancel: no effect.
- State RUN:
  - Accepted request: latch it and go to REBASE.
  - Else if timer expired is high: go to REBASE with no pending request.
- State REBASE (exactly one cycle, req_ready = 0):
  - elapsed = loaded - data_out + tick_edge, computed in 17 bits and saturated to loaded. The tick_edge term compensates for a tick lost to load priority.
  - For each armed channel, remaining -= elapsed, saturating at 0. A channel reaching 0 clears its armed bit and sets its fired bit.
  - The latched request is applied after the rebase:
    - Arm: remaining[ch] = req_count, armed[ch] = 1 (re-arming an armed channel replaces its count). An arm with count 0 sets fired immediately.
    - Cancel: armed[ch] = 0; fired[ch] is untouched.
  - min = smallest remaining among the still-armed channels. If any remain armed: load the timer with min, loaded = min, go to RUN. Else go to IDLE.
- Fire latency: the timer reaches 0 in cycle T; fired[i] is visible at cycle T+2.
- Arm latency: a request accepted in cycle N loads the timer at the N+1 edge.
- Simultaneous events:
  - ack[i] and a set of fired[i] in the same cycle: set wins.
  - Several channels with equal remaining fire in the same REBASE.
  - Expiry and a request in the same RUN cycle are handled in a single REBASE.
- Width rules: all counts are unsigned 16-bit; no wrap-around (subtraction saturates at 0).
- Reset mid-REBASE or mid-RUN: everything clears, no fired flags.

Decomposition:
- Package cdtimer_sched_pkg:
  - state enum {IDLE, RUN, REBASE}.
  - CNT_W = 16.
  - Function sat_sub16(a, b).
- Sub-module: one cdtimer16 instance (the shared timer). The min-finder stays inline as a combinational loop.

Test Plan:
- Arm ch0 = 5 from IDLE, then 5 tick edges -> fired[0] high 2 cycles after the 5th tick edge's count reaches 0; armed = 0; back to IDLE; busy = 0.
- Arm ch1 = 10; after 4 ticks arm ch2 = 3 -> ch2 fires after 3 more ticks (7 total). ch1 then fires after 3 further ticks (10 total); loaded sequence is 10, 3, 3.
- Arm ch0 = 8 and ch3 = 8 -> both fired bits set in the same cycle after 8 ticks.
- Arm ch1 = 6, cancel ch1 after 2 ticks -> state IDLE; fired[1] never set after 20 more ticks.
- Tick edge coincident with the REBASE cycle of an arm (ch0 = 4 pending, arm ch1 = 9 after 1 tick) -> ch0 fires at exactly 4 total ticks and ch1 at 10 total ticks.
- Assert sysreset_n low while ch0 is armed with 3 ticks left -> fired = 0, armed = 0, busy = 0 immediately. After release, ack[0] with fired[0] being set in the same cycle -> fired[0] stays 1.
